// File: rtl/sigma_delta_adc.sv
// -----------------------------------------------------------------------------
// sigma_delta_adc
// First-order sigma-delta ADC front end with a sinc2 (second-order CIC)
// decimator. This block is the capture-side partner of the team's sigma-delta
// DAC.
//
// An external comparator compares the analog input against an RC-filtered copy
// of fb_pin. This block synchronises the comparator output and drives the
// synchronised bit straight back out as the feedback. It then decimates the
// resulting 1-bit stream by R = 2**DECIM_LOG2 into unsigned offset-binary words.
//
// Ports
//    clk          sample / system clock
//    rst          asynchronous active-high reset
//    comp_in      comparator output, asynchronous to clk
//    fb_pin       feedback bit to the RC network (last synchroniser stage)
//    adc_data     decimated sample, unsigned, ADC_BITLEN bits
//    adc_valid    adc_data holds an unconsumed sample
//    adc_ready    consumer takes the sample when adc_valid && adc_ready
//    adc_overrun  one-cycle pulse when a pending sample is overwritten
// -----------------------------------------------------------------------------
module sigma_delta_adc #(
   parameter int ADC_BITLEN  = 16,
   parameter int DECIM_LOG2  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  comp_in,
   output logic                  fb_pin,
   output logic [ADC_BITLEN-1:0] adc_data,
   output logic                  adc_valid,
   input  logic                  adc_ready,
   output logic                  adc_overrun
);

   // W is wide enough for the full comb result (0..R*R). NB is the width
   // after saturation.
   localparam int W  = 2*DECIM_LOG2 + 1;
   localparam int NB = 2*DECIM_LOG2;

   logic [SYNC_STAGES-1:0] r_syncChain;
   logic                   w_q;
   logic [W-1:0]           r_int1;
   logic [W-1:0]           r_int2;
   logic [DECIM_LOG2-1:0]  r_decimCnt;
   logic                   w_tick;
   logic [W-1:0]           r_dly1;
   logic [W-1:0]           r_dly2;
   logic [W-1:0]           w_comb1;
   logic [W-1:0]           w_comb2;
   logic [W-1:0]           r_combOut;
   logic                   r_combValid;
   logic [NB-1:0]          w_sat;
   logic [ADC_BITLEN-1:0]  w_scaled;
   logic [1:0]             r_warmCnt;
   logic                   w_load;
   logic [ADC_BITLEN-1:0]  r_adcData;
   logic                   r_adcValid;
   logic                   r_adcOverrun;

   // Comparator synchroniser. The last stage is the modulator bit itself. It
   // goes to the pin with no extra register, so the loop delay stays at
   // SYNC_STAGES cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_syncChain <= '0;
      end else begin
         r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], comp_in};
      end
   end

   assign w_q    = r_syncChain[SYNC_STAGES-1];
   assign fb_pin = w_q;

   // Integrators and the free-running decimation counter. The integrators
   // are allowed to wrap. The combs difference them modulo 2**W, so the
   // wrap cancels out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_int1     <= '0;
         r_int2     <= '0;
         r_decimCnt <= '0;
      end else begin
         r_int1     <= r_int1 + {{(W-1){1'b0}}, w_q};
         r_int2     <= r_int2 + r_int1;
         r_decimCnt <= r_decimCnt + DECIM_LOG2'(1);
      end
   end

   // R-1 is all ones, so the tick is the all-ones count.
   assign w_tick  = (r_decimCnt == '1);
   assign w_comb1 = r_int2 - r_dly1;
   assign w_comb2 = w_comb1 - r_dly2;

   // Comb stage, updated only on a tick. r_combValid marks the cycle after
   // a tick, when r_combOut holds a fresh result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dly1      <= '0;
         r_dly2      <= '0;
         r_combOut   <= '0;
         r_combValid <= 1'b0;
      end else begin
         r_combValid <= w_tick;
         if (w_tick) begin
            r_dly1    <= r_int2;
            r_dly2    <= w_comb1;
            r_combOut <= w_comb2;
         end
      end
   end

   // Full-scale input gives exactly R*R. That is the only value with the top
   // bit set, so clamp it to all-ones before dropping that bit.
   assign w_sat = r_combOut[NB] ? {NB{1'b1}} : r_combOut[NB-1:0];

   generate
      if (ADC_BITLEN == NB + 1) begin : g_scaleUp
         assign w_scaled = {w_sat, 1'b0};
      end else begin : g_scaleTop
         assign w_scaled = ADC_BITLEN'(w_sat >> (NB - ADC_BITLEN));
      end
   endgenerate

   // The first two comb results after reset are built on unsettled delay
   // history, so they are swallowed here and never reach the output.
   assign w_load = r_combValid && (r_warmCnt == 2'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_warmCnt <= 2'd0;
      end else if (r_combValid && (r_warmCnt != 2'd2)) begin
         r_warmCnt <= r_warmCnt + 2'd1;
      end
   end

   // Output holding register and handshake. A new load always wins. If the
   // old word was still pending and not being taken this cycle, flag an
   // overrun. All outputs are registered, so adc_ready never reaches an
   // output combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_adcData    <= '0;
         r_adcValid   <= 1'b0;
         r_adcOverrun <= 1'b0;
      end else if (w_load) begin
         r_adcData    <= w_scaled;
         r_adcValid   <= 1'b1;
         r_adcOverrun <= r_adcValid && !adc_ready;
      end else begin
         r_adcOverrun <= 1'b0;
         if (r_adcValid && adc_ready) begin
            r_adcValid <= 1'b0;
         end
      end
   end

   assign adc_data    = r_adcData;
   assign adc_valid   = r_adcValid;
   assign adc_overrun = r_adcOverrun;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// -----------------------------------------------------------------------------
// tb_sigma_delta_adc
// Self-checking bench for sigma_delta_adc with DECIM_LOG2=4, ADC_BITLEN=8 and
// SYNC_STAGES=2.
//
// The reference model keeps the history of sampled comparator bits. Each
// output word is the sum of R successive R-wide moving-window ones counts
// (a sinc2 response), then saturated and scaled. The handshake is modelled
// from its accept / load / overrun rules.
// -----------------------------------------------------------------------------
module tb_sigma_delta_adc;

   localparam int D  = 4;
   localparam int R  = 16;
   localparam int AB = 8;
   localparam int S  = 2;
   localparam int HN = 4096;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          compIn   = 1'b0;
   logic          adcReady = 1'b0;
   logic          fbPin;
   logic          adcValid;
   logic          adcOverrun;
   logic [AB-1:0] adcData;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit hist [0:HN-1];

   logic          expFb      = 1'b0;
   logic          expValid   = 1'b0;
   logic          expOverrun = 1'b0;
   logic [AB-1:0] expData    = '0;

   sigma_delta_adc #(
      .ADC_BITLEN (AB),
      .DECIM_LOG2 (D),
      .SYNC_STAGES(S)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .comp_in    (compIn),
      .fb_pin     (fbPin),
      .adc_data   (adcData),
      .adc_valid  (adcValid),
      .adc_ready  (adcReady),
      .adc_overrun(adcOverrun)
   );

   always #5 clk = ~clk;

   // Modulator bit seen in cycle k. This is the comparator value sampled
   // S-1 edges earlier; before any sample it is zero.
   function automatic bit qAt(input int k);
      int idx;
      idx = k - S + 1;
      if (idx >= 1 && idx <= cyc && idx < HN) return hist[idx];
      return 1'b0;
   endfunction

   // Decimated word produced by the tick in cycle t.
   function automatic logic [AB-1:0] cicValue(input int t);
      int acc;
      acc = 0;
      for (int m = t - R; m < t; m++) begin
         for (int j = m - R; j < m; j++) begin
            acc += int'(qAt(j));
         end
      end
      if (acc > R*R - 1) acc = R*R - 1;
      if (AB == 2*D + 1) return AB'(acc << 1);
      return AB'(acc >> (2*D - AB));
   endfunction

   // Advance one clock, update the reference model, and park at the
   // following negedge, where outputs are stable and the next inputs are
   // driven.
   task automatic stepCycle();
      bit   load;
      logic rdy;
      @(posedge clk);
      cyc++;
      if (cyc < HN) hist[cyc] = compIn;
      rdy  = adcReady;
      load = (cyc >= 2) && (((cyc - 2) % R) == R - 1) && (((cyc - 2) / R + 1) >= 3);
      if (load) begin
         expOverrun = expValid && !rdy;
         expValid   = 1'b1;
         expData    = cicValue(cyc - 2);
      end else begin
         expOverrun = 1'b0;
         if (expValid && rdy) expValid = 1'b0;
      end
      expFb = qAt(cyc);
      @(negedge clk);
   endtask

   task automatic applyRelease();
      @(negedge clk);
      rst        = 1'b0;
      cyc        = 0;
      expFb      = 1'b0;
      expValid   = 1'b0;
      expOverrun = 1'b0;
      expData    = '0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({fbPin, adcValid, adcOverrun, adcData} !== 11'b0) begin
         fails++;
         $display("[TB] FAIL reset_held got fb=%b v=%b ov=%b d=%h required all zero", fbPin, adcValid, adcOverrun, adcData);
      end
      applyRelease();
      tests++;
      if ({fbPin, adcValid, adcOverrun, adcData} !== 11'b0) begin
         fails++;
         $display("[TB] FAIL reset_release got fb=%b v=%b ov=%b d=%h required all zero", fbPin, adcValid, adcOverrun, adcData);
      end
   endtask

   task automatic test_const_one();
      rst = 1'b1;
      compIn   = 1'b1;
      adcReady = 1'b1;
      applyRelease();
      for (int i = 0; i < 120; i++) begin
         stepCycle();
         tests++;
         if ({fbPin, adcValid, adcOverrun, adcData} !== {expFb, expValid, expOverrun, expData}) begin
            fails++;
            $display("[TB] FAIL const_one cyc=%0d got fb=%b v=%b ov=%b d=%h required fb=%b v=%b ov=%b d=%h",
                     cyc, fbPin, adcValid, adcOverrun, adcData, expFb, expValid, expOverrun, expData);
         end
         if (cyc == 1 || cyc == 2) begin
            tests++;
            if (fbPin !== (cyc == 2)) begin
               fails++;
               $display("[TB] FAIL fb_rise cyc=%0d got %b required %b", cyc, fbPin, (cyc == 2));
            end
         end
         if (adcValid === 1'b1) begin
            tests++;
            if (adcData !== 8'hFF) begin
               fails++;
               $display("[TB] FAIL full_scale got %h required ff", adcData);
            end
         end
      end
   endtask

   task automatic test_const_zero();
      int nValid;
      rst = 1'b1;
      compIn   = 1'b0;
      adcReady = 1'b1;
      applyRelease();
      nValid = 0;
      for (int i = 0; i < 120; i++) begin
         stepCycle();
         tests++;
         if ({fbPin, adcValid, adcOverrun, adcData} !== {expFb, expValid, expOverrun, expData}) begin
            fails++;
            $display("[TB] FAIL const_zero cyc=%0d got fb=%b v=%b ov=%b d=%h required fb=%b v=%b ov=%b d=%h",
                     cyc, fbPin, adcValid, adcOverrun, adcData, expFb, expValid, expOverrun, expData);
         end
         if (adcValid === 1'b1) begin
            nValid++;
            tests++;
            if ((cyc % R) != 1 || adcData !== 8'h00) begin
               fails++;
               $display("[TB] FAIL zero_pulse cyc=%0d got d=%h required cyc%%16=1 d=00", cyc, adcData);
            end
         end
      end
      // Cycles 49, 65, 81, 97 and 113 carry a valid word.
      tests++;
      if (nValid != 5) begin
         fails++;
         $display("[TB] FAIL zero_count got %0d required 5", nValid);
      end
   endtask

   task automatic test_toggle();
      rst = 1'b1;
      adcReady = 1'b1;
      applyRelease();
      for (int i = 0; i < 100; i++) begin
         compIn = ~compIn;
         stepCycle();
         tests++;
         if ({fbPin, adcValid, adcOverrun, adcData} !== {expFb, expValid, expOverrun, expData}) begin
            fails++;
            $display("[TB] FAIL toggle cyc=%0d got fb=%b v=%b ov=%b d=%h required fb=%b v=%b ov=%b d=%h",
                     cyc, fbPin, adcValid, adcOverrun, adcData, expFb, expValid, expOverrun, expData);
         end
         if (adcValid === 1'b1) begin
            tests++;
            if (adcData < 8'h7F || adcData > 8'h81) begin
               fails++;
               $display("[TB] FAIL half_scale got %h required 80 +-1", adcData);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int nOver;
      nOver = 0;
      adcReady = 1'b0;
      for (int i = 0; i < 40; i++) begin
         compIn = 1'($urandom);
         stepCycle();
         if (adcOverrun === 1'b1) nOver++;
         tests++;
         if ({fbPin, adcValid, adcOverrun, adcData} !== {expFb, expValid, expOverrun, expData}) begin
            fails++;
            $display("[TB] FAIL backpressure cyc=%0d got fb=%b v=%b ov=%b d=%h required fb=%b v=%b ov=%b d=%h",
                     cyc, fbPin, adcValid, adcOverrun, adcData, expFb, expValid, expOverrun, expData);
         end
      end
      tests++;
      if (nOver < 1) begin
         fails++;
         $display("[TB] FAIL overrun_seen got %0d required >=1", nOver);
      end
      // Release ready on a cycle with no load behind it.
      for (int i = 0; i < R && (cyc % R) == 0; i++) stepCycle();
      adcReady = 1'b1;
      stepCycle();
      tests++;
      if (adcValid !== 1'b0 || adcOverrun !== 1'b0) begin
         fails++;
         $display("[TB] FAIL release_drop got v=%b ov=%b required v=0 ov=0", adcValid, adcOverrun);
      end
   endtask

   task automatic test_back_to_back();
      adcReady = 1'b0;
      for (int i = 0; i < 3*R && !expValid; i++) stepCycle();
      // The next edge loads when cyc%R == 0, so the accept coincides with it.
      for (int i = 0; i < R && (cyc % R) != 0; i++) stepCycle();
      compIn   = 1'b1;
      adcReady = 1'b1;
      stepCycle();
      tests++;
      if (adcValid !== 1'b1 || adcOverrun !== 1'b0 || adcData !== expData || expOverrun !== 1'b0) begin
         fails++;
         $display("[TB] FAIL accept_load got v=%b ov=%b d=%h required v=1 ov=0 d=%h", adcValid, adcOverrun, adcData, expData);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         compIn   = 1'($urandom);
         adcReady = ($urandom_range(0, 3) != 0);
         stepCycle();
         tests++;
         if ({fbPin, adcValid, adcOverrun, adcData} !== {expFb, expValid, expOverrun, expData}) begin
            fails++;
            $display("[TB] FAIL random cyc=%0d got fb=%b v=%b ov=%b d=%h required fb=%b v=%b ov=%b d=%h",
                     cyc, fbPin, adcValid, adcOverrun, adcData, expFb, expValid, expOverrun, expData);
         end
      end
   endtask

   task automatic test_mid_reset();
      int firstValid;
      adcReady = 1'b1;
      repeat ($urandom_range(3, 12)) stepCycle();
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if ({fbPin, adcValid, adcOverrun, adcData} !== 11'b0) begin
         fails++;
         $display("[TB] FAIL async_clear got fb=%b v=%b ov=%b d=%h required all zero", fbPin, adcValid, adcOverrun, adcData);
      end
      applyRelease();
      firstValid = -1;
      for (int i = 0; i < 100 && firstValid < 0; i++) begin
         compIn = 1'($urandom);
         stepCycle();
         tests++;
         if ({fbPin, adcValid, adcOverrun, adcData} !== {expFb, expValid, expOverrun, expData}) begin
            fails++;
            $display("[TB] FAIL post_reset cyc=%0d got fb=%b v=%b ov=%b d=%h required fb=%b v=%b ov=%b d=%h",
                     cyc, fbPin, adcValid, adcOverrun, adcData, expFb, expValid, expOverrun, expData);
         end
         if (adcValid === 1'b1) firstValid = cyc;
      end
      // The third tick lands in cycle 3R-1, so its word is valid two cycles later.
      tests++;
      if (firstValid != 3*R + 1) begin
         fails++;
         $display("[TB] FAIL first_valid got cycle %0d required %0d", firstValid, 3*R + 1);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL timeout");
      $fatal(1, "[TB] time limit reached");
   end

   initial begin
      test_reset();
      test_const_one();
      test_const_zero();
      test_toggle();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
